matrix_row_packer: RTL and testbench
====================================

# matrix_row_packer

Upstream feeder for the accelerator's input row buffer. Accepts a serial stream of FP32 words, packs `SIZE` consecutive words into one `SIZE*WIDTH`-bit row and hands rows to the buffer with a row index and a last-row flag. It tiles a `MATRIX_SIZE`x`MATRIX_SIZE` operand into `(MATRIX_SIZE/SIZE)^2` tiles of `SIZE+1` rows each; row index `SIZE` is the tile's closing row and carries `in_last`. It also signals completion of the whole matrix.

## Interface
- `SIZE`, 8, words per row; buffer dimension
- `WIDTH`, 32, word width (FP32)
- `MATRIX_SIZE`, 32, matrix dimension; must be a multiple of `SIZE`
- `clk`  in  1  clock; one clock for the whole block
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle pulse; begins a matrix transfer
- `s_data`  in  WIDTH  input word
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  block can accept `s_data`
- `data_in`  out  SIZE*WIDTH  packed row; word k at bits `[k*WIDTH +: WIDTH]`
- `index_in`  out  $clog2(SIZE)+1  row index, 0..SIZE
- `in_valid`  out  1  row valid toward the buffer
- `in_last`  out  1  asserted with `in_valid` when `index_in == SIZE`
- `in_ready`  in  1  buffer can take a row
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse after the final row of the final tile is transferred

## Operation
- FSM states: IDLE, FILL, SEND, GAP.
- IDLE: `s_ready=0`, `busy=0`. `start` moves to FILL and clears the word, row and tile counters.
- FILL: `s_ready=1`. Each `s_valid&&s_ready` writes `s_data` into word slot `wcnt`, then increments `wcnt`. On acceptance of word `SIZE-1`: `wcnt` wraps to 0 and the FSM moves to SEND.
- SEND: `in_valid=1`. `index_in` = row counter. `in_last = (row == SIZE)`. `data_in` and `index_in` stay stable until `in_valid&&in_ready`. A transfer always moves to GAP.
- GAP: one cycle with `in_valid=0`, because the buffer requires a deasserted-valid cycle between rows.
  - Row < SIZE: row++, then FILL.
  - Row == SIZE: row wraps to 0 and tile++. If the tile just finished was the last (`tile == (MATRIX_SIZE/SIZE)^2 - 1`), pulse `done` and go to IDLE; otherwise go to FILL.
- Counts: one tile is `(SIZE+1)*SIZE` words (72 at defaults). A full matrix is 16 tiles, 1152 words.
- `start` while `busy` is ignored.
- `s_valid` outside FILL is not consumed.
- `in_ready` dropping while `in_valid` is high: hold the row; no transfer occurs.
- Reset mid-operation: everything clears immediately and the FSM goes to IDLE; a partial row is discarded.

## Timing
- Reset values: `s_ready=0`, `in_valid=0`, `in_last=0`, `index_in=0`, `data_in=0`, `busy=0`, `done=0`.
- All outputs are registered except `s_ready`, which decodes from state (FILL, or the skid condition).
- Latency:
  - With `in_ready` always high, the last word of a row is accepted in cycle N and `in_valid` rises in cycle N+1.
  - At full input rate, the minimum period is SIZE+2 cycles per row.
- `done` rises the cycle after GAP of the final row, in the same edge as the return to IDLE.
- `busy` goes high the cycle after `start` and low together with `done`.

## Configuration
- Macro `ROW_SKID_EN`.
- Defined: a second row register is added. FILL of row j+1 may run while row j is in SEND/GAP. `s_ready` stays high while the spare register is empty.
  - Sustained rate is SIZE cycles per row whenever `in_ready` returns within SIZE-2 cycles.
  - Row order, indices and `in_last` placement are unchanged.
- Undefined: a single row register. `s_ready=0` throughout SEND and GAP.

## Structure
- Shared package `accel_pkg` holds:
  - FSM state enum
  - default `SIZE`/`WIDTH`/`MATRIX_SIZE` constants
  - derived `TILES` and `ROW_IDX_W` constants
- Sub-module `matrix_row_slot`: one row register plus its full flag, written word-by-word and read whole. It is instantiated once, or twice under `ROW_SKID_EN`.

## Test plan
- Reset, then `start` with words 0x3F800000+i, i=0..71, `in_ready=1`:
  - 9 row transfers with `index_in` 0..8
  - row 0 word 0 = 0x3F800000, row 8 word 7 = 0x3F800047
  - `in_last` only on index 8
  - every `in_valid` pulse followed by ≥1 low cycle
- Full matrix of 1152 words, each word = its sequence number:
  - 144 rows, 16 `in_last` pulses
  - exactly one `done` pulse, after the 144th transfer
  - `busy` falls with `done`
- Hold `in_ready=0` for 20 cycles during SEND of row 3:
  - `in_valid`, `data_in`, `index_in` stay stable
  - `s_ready=0` without `ROW_SKID_EN`
  - exactly one transfer when `in_ready` returns
- Assert `rst` after 5 words of row 2 of tile 0:
  - all outputs return to reset values asynchronously
  - a new `start` then begins at row 0, tile 0, word 0
- `start` pulsed while `busy`, and `s_valid=1` held in IDLE: no state change, no word consumed.
- With `ROW_SKID_EN` and `in_ready=1`, stream continuously: 72 words in 72 consecutive cycles with `s_ready` never dropping.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator input path: FSM state encoding,
// default geometry and constants derived from it.
package accel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_SEND,
    ST_GAP
  } state_t;

  localparam int unsigned DEF_SIZE        = 8;
  localparam int unsigned DEF_WIDTH       = 32;
  localparam int unsigned DEF_MATRIX_SIZE = 32;

  localparam int unsigned TILES     = (DEF_MATRIX_SIZE / DEF_SIZE) * (DEF_MATRIX_SIZE / DEF_SIZE);
  localparam int unsigned ROW_IDX_W = $clog2(DEF_SIZE) + 1;

endpackage

// File: rtl/matrix_row_slot.sv
// One row register written word-by-word and read whole, with a full flag
// that sets on the final word and clears when the row is handed off.
module matrix_row_slot #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [$clog2(SIZE)-1:0]   i_wr_idx,
  input  logic [WIDTH-1:0]          i_wr_data,
  input  logic                      i_clr,
  output logic [SIZE*WIDTH-1:0]     o_data,
  output logic                      o_full
);

  localparam int unsigned L_IDX_W = $clog2(SIZE);

  logic [SIZE-1:0][WIDTH-1:0] r_words;
  logic                       r_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_words <= '0;
      r_full  <= 1'b0;
    end else begin
      if (i_wr_en) begin
        r_words[i_wr_idx] <= i_wr_data;
      end
      if (i_clr) begin
        r_full <= 1'b0;
      end
      if (i_wr_en && (i_wr_idx == L_IDX_W'(SIZE - 1))) begin
        r_full <= 1'b1;
      end
    end
  end

  assign o_data = r_words;
  assign o_full = r_full;

endmodule

// File: rtl/matrix_row_packer.sv
// Packs SIZE serial words per row and emits (SIZE+1)-row tiles over a full
// MATRIX_SIZE operand. Define ROW_SKID_EN for a second, ping-pong row slot.
module matrix_row_packer
  import accel_pkg::*;
#(
  parameter int unsigned SIZE        = DEF_SIZE,
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [SIZE*WIDTH-1:0]   data_in,
  output logic [$clog2(SIZE):0]   index_in,
  output logic                    in_valid,
  output logic                    in_last,
  input  logic                    in_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned L_TILES  = (MATRIX_SIZE / SIZE) * (MATRIX_SIZE / SIZE);
  localparam int unsigned L_IDX_W  = $clog2(SIZE) + 1;
  localparam int unsigned L_WCNT_W = $clog2(SIZE);
  localparam int unsigned L_TILE_W = (L_TILES > 1) ? $clog2(L_TILES) : 1;
`ifdef ROW_SKID_EN
  localparam int unsigned L_SLOTS  = 2;
  localparam int unsigned L_ROWS   = L_TILES * (SIZE + 1);
  localparam int unsigned L_WROW_W = $clog2(L_ROWS);
`else
  localparam int unsigned L_SLOTS  = 1;
`endif

  state_t                r_state, w_state_nxt;
  logic [L_WCNT_W-1:0]   r_wcnt;
  logic [L_IDX_W-1:0]    r_row, w_row_nxt;
  logic [L_TILE_W-1:0]   r_tile, w_tile_nxt;
  logic                  w_done_nxt;
  logic                  w_start_go;
  logic                  w_accept;
  logic                  w_row_filled;
  logic                  w_xfer;
  logic                  w_rd_full;
  logic                  w_wptr, w_rptr;
  logic [L_SLOTS-1:0]    w_full;
  logic [SIZE*WIDTH-1:0] w_slot_data [L_SLOTS];

  assign w_start_go   = (r_state == ST_IDLE) && start;
  assign w_accept     = s_valid && s_ready;
  assign w_row_filled = w_accept && (r_wcnt == L_WCNT_W'(SIZE - 1));
  assign w_xfer       = (r_state == ST_SEND) && in_ready;

  for (genvar g = 0; g < L_SLOTS; g++) begin : g_slot
    matrix_row_slot #(
      .SIZE (SIZE),
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .i_wr_en  (w_accept && (w_wptr == 1'(g))),
      .i_wr_idx (r_wcnt),
      .i_wr_data(s_data),
      .i_clr    (w_xfer && (w_rptr == 1'(g))),
      .o_data   (w_slot_data[g]),
      .o_full   (w_full[g])
    );
  end

`ifdef ROW_SKID_EN
  logic                r_wptr, r_rptr, r_fill_done;
  logic [L_WROW_W-1:0] r_wrow;

  // Write side runs ahead of the FSM; it stops once the matrix's last row is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_fill_done <= 1'b0;
      r_wrow      <= '0;
    end else if (w_start_go) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_fill_done <= 1'b0;
      r_wrow      <= '0;
    end else begin
      if (w_row_filled) begin
        r_wptr <= ~r_wptr;
        if (r_wrow == L_WROW_W'(L_ROWS - 1)) begin
          r_fill_done <= 1'b1;
          r_wrow      <= '0;
        end else begin
          r_wrow <= r_wrow + 1'b1;
        end
      end
      if (w_xfer) begin
        r_rptr <= ~r_rptr;
      end
    end
  end

  assign w_wptr    = r_wptr;
  assign w_rptr    = r_rptr;
  assign s_ready   = (r_state != ST_IDLE) && !r_fill_done && !w_full[w_wptr];
  assign w_rd_full = w_full[w_rptr] || (w_row_filled && (r_wptr == r_rptr));
`else
  assign w_wptr    = 1'b0;
  assign w_rptr    = 1'b0;
  assign s_ready   = (r_state == ST_FILL);
  assign w_rd_full = w_full[w_rptr] || w_row_filled;
`endif

  assign data_in  = w_slot_data[w_rptr];
  assign index_in = r_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wcnt <= '0;
    end else if (w_start_go) begin
      r_wcnt <= '0;
    end else if (w_accept) begin
      r_wcnt <= (r_wcnt == L_WCNT_W'(SIZE - 1)) ? '0 : r_wcnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_tile_nxt  = r_tile;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FILL;
          w_row_nxt   = '0;
          w_tile_nxt  = '0;
        end
      end
      ST_FILL: begin
        if (w_rd_full) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (in_ready) begin
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_row == L_IDX_W'(SIZE)) begin
          w_row_nxt = '0;
          if (r_tile == L_TILE_W'(L_TILES - 1)) begin
            w_tile_nxt  = '0;
            w_state_nxt = ST_IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_tile_nxt  = r_tile + 1'b1;
            w_state_nxt = ST_FILL;
          end
        end else begin
          w_row_nxt   = r_row + 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_row    <= '0;
      r_tile   <= '0;
      in_valid <= 1'b0;
      in_last  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_row    <= w_row_nxt;
      r_tile   <= w_tile_nxt;
      in_valid <= (w_state_nxt == ST_SEND);
      in_last  <= (w_state_nxt == ST_SEND) && (w_row_nxt == L_IDX_W'(SIZE));
      busy     <= (w_state_nxt != ST_IDLE);
      done     <= w_done_nxt;
    end
  end

endmodule

// File: tb/tb_matrix_row_packer.sv
// Randomized self-checking bench for matrix_row_packer against a word-queue
// reference model of rows, indices, tile closings and completion.
module tb_matrix_row_packer;

  localparam int unsigned SIZE        = 8;
  localparam int unsigned WIDTH       = 32;
  localparam int unsigned MATRIX_SIZE = 32;
  localparam int unsigned TILES       = (MATRIX_SIZE / SIZE) * (MATRIX_SIZE / SIZE);
  localparam int unsigned ROWS        = TILES * (SIZE + 1);
  localparam int unsigned DW          = SIZE * WIDTH;
  localparam int unsigned IW          = $clog2(SIZE) + 1;
`ifdef ROW_SKID_EN
  localparam int unsigned T1_CYCLES   = SIZE * (SIZE + 1);
`else
  localparam int unsigned T1_CYCLES   = (SIZE + 2) * (SIZE + 1) - 2;
`endif

  logic             clk, rst, start, s_valid, s_ready;
  logic [WIDTH-1:0] s_data;
  logic [DW-1:0]    data_in;
  logic [IW-1:0]    index_in;
  logic             in_valid, in_last, in_ready, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [WIDTH-1:0] exp_words[$];
  logic [DW-1:0]    got_rows[$];
  int unsigned      xfer_cnt, last_cnt, done_cnt;
  bit               prev_xfer, prev_hold, pend_lat, prev_busy, lat_en;
  logic [DW-1:0]    held_data, exp_row, tmp_row;
  logic [IW-1:0]    held_idx;
  int unsigned      cyc;

  matrix_row_packer #(
    .SIZE       (SIZE),
    .WIDTH      (WIDTH),
    .MATRIX_SIZE(MATRIX_SIZE)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .data_in (data_in),
    .index_in(index_in),
    .in_valid(in_valid),
    .in_last (in_last),
    .in_ready(in_ready),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: row k of the matrix is accepted words k*SIZE..k*SIZE+SIZE-1,
  // with index k mod (SIZE+1) and the tile closing on index SIZE.
  always @(negedge clk) begin
    if (rst) begin
      exp_words.delete();
      got_rows.delete();
      xfer_cnt  = 0;
      last_cnt  = 0;
      done_cnt  = 0;
      prev_xfer = 0;
      prev_hold = 0;
      pend_lat  = 0;
      prev_busy = 0;
    end else begin
      if (pend_lat) check_eq("latency", in_valid, 1);
      pend_lat = 0;
      if (prev_xfer) check_eq("gap_after_row", in_valid, 0);
      if (prev_hold) begin
        check_eq("hold_valid", in_valid, 1);
        check_eq("hold_data", data_in, held_data);
        check_eq("hold_index", index_in, held_idx);
      end
      if (in_last) check_eq("last_wo_valid", in_valid, 1);
      if (in_valid && in_ready) begin
        if (exp_words.size() >= (xfer_cnt + 1) * SIZE) begin
          for (int j = 0; j < SIZE; j++) exp_row[j*WIDTH +: WIDTH] = exp_words[xfer_cnt*SIZE + j];
          check_eq("row_data", data_in, exp_row);
        end else begin
          check_eq("row_early", exp_words.size(), (xfer_cnt + 1) * SIZE);
        end
        check_eq("row_index", index_in, xfer_cnt % (SIZE + 1));
        check_eq("row_last", in_last, (xfer_cnt % (SIZE + 1)) == SIZE);
        if (in_last) last_cnt++;
        got_rows.push_back(data_in);
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        check_eq("done_after_rows", xfer_cnt, ROWS);
        check_eq("busy_with_done", busy, 0);
        check_eq("busy_before_done", prev_busy, 1);
      end
      if (s_valid && s_ready) begin
        exp_words.push_back(s_data);
        if (lat_en && (exp_words.size() % SIZE == 0)) pend_lat = 1;
      end
      prev_xfer = in_valid && in_ready;
      prev_hold = in_valid && !in_ready;
      held_data = data_in;
      held_idx  = index_in;
      prev_busy = busy;
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_in_valid", in_valid, 0);
    check_eq("rst_in_last", in_last, 0);
    check_eq("rst_index", index_in, 0);
    check_eq("rst_data", data_in, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_vals();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_words(input int unsigned n, input logic [WIDTH-1:0] base,
                            input int unsigned gap_pct, output int unsigned cycles);
    bit          acc;
    int unsigned t;
    cycles = 0;
    for (int unsigned i = 0; i < n; i++) begin
      while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1 cycles++;
      end
      s_valid = 1'b1;
      s_data  = base + i;
      t = 0;
      do begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1 t++;
      end while (!acc && t < 2000);
      cycles += t;
      if (!acc) begin
        check_eq("accept_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_xfers(input int unsigned n, input int unsigned budget);
    int unsigned t = 0;
    while (xfer_cnt < n && t < budget) begin
      @(negedge clk);
      #1 t++;
    end
    check_eq("wait_xfers", xfer_cnt, n);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = '0; in_ready = 1'b1; lat_en = 0;
    #2 rst = 1'b1;
    #1 check_reset_vals();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // One tile at full rate with the buffer always ready.
    lat_en = 1;
    pulse_start();
    send_words(SIZE * (SIZE + 1), 32'h3F80_0000, 0, cyc);
    check_eq("t1_cycles", cyc, T1_CYCLES);
    wait_xfers(SIZE + 1, 200);
    repeat (20) @(negedge clk);
    #1 check_eq("t1_rows", xfer_cnt, SIZE + 1);
    check_eq("t1_last_cnt", last_cnt, 1);
    tmp_row = got_rows[0];
    check_eq("t1_r0w0", tmp_row[WIDTH-1:0], 32'h3F80_0000);
    tmp_row = got_rows[SIZE];
    check_eq("t1_r8w7", tmp_row[DW-1 -: WIDTH], 32'h3F80_0047);

    // Reset in the middle of row 2, then restart from the beginning.
    do_reset();
    pulse_start();
    send_words(2 * SIZE + 5, 32'h5000_0000, 0, cyc);
    do_reset();
    pulse_start();
    send_words(SIZE * (SIZE + 1), 32'hA000_0000, 0, cyc);
    wait_xfers(SIZE + 1, 200);
    tmp_row = got_rows[0];
    check_eq("t2_restart_w0", tmp_row[WIDTH-1:0], 32'hA000_0000);
    lat_en = 0;

    // Input offered while idle must not be taken.
    do_reset();
    s_valid = 1'b1;
    s_data  = 32'hDEAD_BEEF;
    repeat (8) begin
      @(negedge clk);
      check_eq("idle_s_ready", s_ready, 0);
      check_eq("idle_busy", busy, 0);
    end
    #1 check_eq("idle_consumed", exp_words.size(), 0);
    s_valid = 1'b0;

    // Full matrix with random gaps, a long stall on row 3 and a stray start.
    pulse_start();
    fork
      send_words(ROWS * SIZE, 32'h0, 20, cyc);
      begin : stall
        int unsigned t;
        t = 0;
        while (xfer_cnt < 3 && t < 2000) begin
          @(negedge clk);
          #1 t++;
        end
        @(posedge clk);
        #1 in_ready = 1'b0;
        t = 0;
        while (!in_valid && t < 2000) begin
          @(negedge clk);
          t++;
        end
        check_eq("t4_stall_row", index_in, 3);
        repeat (20) begin
          @(negedge clk);
`ifndef ROW_SKID_EN
          check_eq("t4_stall_sready", s_ready, 0);
`endif
          check_eq("t4_stall_valid", in_valid, 1);
        end
        #1 check_eq("t4_stall_noxfer", xfer_cnt, 3);
        @(posedge clk);
        #1 in_ready = 1'b1;
        @(negedge clk);
        #1 check_eq("t4_release_one", xfer_cnt, 4);
        t = 0;
        while (done_cnt == 0 && t < 20000) begin
          @(posedge clk);
          #1 in_ready = ($urandom_range(3) != 0);
          t++;
        end
        in_ready = 1'b1;
      end
      begin
        repeat (150) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    join
    check_eq("t4_done_cnt", done_cnt, 1);
    check_eq("t4_rows", xfer_cnt, ROWS);
    check_eq("t4_last_cnt", last_cnt, TILES);
    repeat (10) @(negedge clk);
    #1 check_eq("t4_busy_end", busy, 0);
    check_eq("t4_done_once", done_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

endmodule
